// File: rtl/mif_line_master.sv
`default_nettype none
// ============================================================================
// Module   : mif_line_master
// Purpose  : Initiator side of the MIF memory interface. Converts one
//            line-wide client request into a single MIF transaction: one
//            command handshake followed by BEATS data beats. Writes stream
//            the latched line out beat by beat. Reads gather BEATS response
//            beats into the line buffer and return the whole line to the
//            client. Only one transaction is in flight at a time.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            cl_req_*             - client line request (valid/ready)
//            cl_resp_*            - client read-line return (valid/ready)
//            wr_done              - one-cycle pulse once a write line is sent
//            err                  - sticky flag: response beat with wrong tag
//            mem_req_*            - MIF command channel (valid/ready)
//            mem_req_data_*       - MIF write-beat channel (valid/ready)
//            mem_resp_*           - MIF read-beat channel (no backpressure)
// Revision : 1.0 - initial release
// ============================================================================
module mif_line_master #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cl_req_valid,
  output logic                       cl_req_ready,
  input  logic                       cl_req_rw,
  input  logic [ADDR_BITS-1:0]       cl_req_addr,
  input  logic [TAG_BITS-1:0]        cl_req_tag,
  input  logic [BEATS*DATA_BITS-1:0] cl_req_data,
  output logic                       cl_resp_valid,
  input  logic                       cl_resp_ready,
  output logic [BEATS*DATA_BITS-1:0] cl_resp_data,
  output logic [TAG_BITS-1:0]        cl_resp_tag,
  output logic                       wr_done,
  output logic                       err,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_rw,
  output logic [ADDR_BITS-1:0]       mem_req_addr,
  output logic [TAG_BITS-1:0]        mem_req_tag,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [DATA_BITS-1:0]       mem_req_data_bits,
  input  logic                       mem_resp_valid,
  input  logic [DATA_BITS-1:0]       mem_resp_data,
  input  logic [TAG_BITS-1:0]        mem_resp_tag
);

  localparam int                C_BEAT_W    = $clog2(BEATS);
  localparam int                C_LINE_W    = BEATS * DATA_BITS;
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(BEATS - 1);
  localparam logic [C_BEAT_W-1:0] C_BEAT_ONE  = C_BEAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [C_BEAT_W-1:0]   beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  wr_done_q, wr_done_d;

  // Request fields and line buffer: loaded on acceptance, never reset.
  // The same buffer holds the outgoing write line or the incoming read line.
  logic                  rw_q, rw_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [C_LINE_W-1:0]   line_q, line_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      err_q     <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      wr_done_q <= wr_done_d;
    end
  end

  always_ff @(posedge clk) begin
    rw_q   <= rw_d;
    addr_q <= addr_d;
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    err_d              = err_q;
    wr_done_d          = 1'b0;
    rw_d               = rw_q;
    addr_d             = addr_q;
    tag_d              = tag_q;
    line_d             = line_q;
    cl_req_ready       = 1'b0;
    cl_resp_valid      = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        cl_req_ready = 1'b1;
        if (cl_req_valid) begin
          rw_d    = cl_req_rw;
          addr_d  = cl_req_addr;
          tag_d   = cl_req_tag;
          line_d  = cl_req_data;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = rw_q ? S_WDATA : S_RWAIT;
        end
      end

      S_WDATA: begin
        mem_req_data_valid = 1'b1;
        if (mem_req_data_ready) begin
          // Counter is exactly log2(BEATS) wide, so the last beat wraps to 0.
          beat_d = beat_q + C_BEAT_ONE;
          if (beat_q == C_LAST_BEAT) begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end

      S_RWAIT: begin
        if (mem_resp_valid) begin
          if (mem_resp_tag == tag_q) begin
            line_d[int'(beat_q)*DATA_BITS +: DATA_BITS] = mem_resp_data;
            beat_d = beat_q + C_BEAT_ONE;
            if (beat_q == C_LAST_BEAT) begin
              state_d = S_RESP;
            end
          end else begin
            // Foreign beat: discard it and remember that it happened.
            err_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        cl_resp_valid = 1'b1;
        if (cl_resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cl_resp_data      = line_q;
  assign cl_resp_tag       = tag_q;
  assign wr_done           = wr_done_q;
  assign err               = err_q;
  assign mem_req_rw        = rw_q;
  assign mem_req_addr      = addr_q;
  assign mem_req_tag       = tag_q;
  assign mem_req_data_bits = line_q[int'(beat_q)*DATA_BITS +: DATA_BITS];

endmodule
`default_nettype wire

// File: tb/tb_mif_line_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mif_line_master
// Purpose  : Self-checking bench for mif_line_master. The bench plays both
//            the client and a MIF responder backed by a line-granular memory
//            model (associative array keyed by line address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mif_line_master;

  localparam int AW = 26;
  localparam int TW = 5;
  localparam int DW = 128;
  localparam int NB = 4;
  localparam int LW = NB * DW;

  logic          clk;
  logic          reset;
  logic          cl_req_valid, cl_req_ready, cl_req_rw;
  logic [AW-1:0] cl_req_addr;
  logic [TW-1:0] cl_req_tag;
  logic [LW-1:0] cl_req_data;
  logic          cl_resp_valid, cl_resp_ready;
  logic [LW-1:0] cl_resp_data;
  logic [TW-1:0] cl_resp_tag;
  logic          wr_done, err;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;

  mif_line_master #(
    .ADDR_BITS(AW), .TAG_BITS(TW), .DATA_BITS(DW), .BEATS(NB)
  ) dut (
    .clk(clk), .reset(reset),
    .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready), .cl_req_rw(cl_req_rw),
    .cl_req_addr(cl_req_addr), .cl_req_tag(cl_req_tag), .cl_req_data(cl_req_data),
    .cl_resp_valid(cl_resp_valid), .cl_resp_ready(cl_resp_ready),
    .cl_resp_data(cl_resp_data), .cl_resp_tag(cl_resp_tag),
    .wr_done(wr_done), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory seen by the responder: whole lines per address.
  logic [LW-1:0] mem_model [logic [AW-1:0]];

  // Observations of the most recent transaction (t counts cycles from the
  // cycle the client request is presented, which is t0).
  int            o_cmd_cnt, o_cmd_cyc, o_done_cyc, o_wr_done_cnt;
  bit            o_first_cmd, o_cmd_unstable, o_dv_early, o_resp_unstable, o_stall_violation, o_aborted;
  logic          o_cmd_rw;
  logic [AW-1:0] o_cmd_addr;
  logic [TW-1:0] o_cmd_tag;
  logic [DW-1:0] o_wbeats[$];
  logic [LW-1:0] o_resp_data;
  logic [TW-1:0] o_resp_tag;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [LW-1:0] pack_wbeats();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < o_wbeats.size() && i < NB; i++) r[i*DW +: DW] = o_wbeats[i];
    return r;
  endfunction

  task automatic idle_inputs();
    cl_req_valid = 1'b0; cl_req_rw = 1'b0; cl_req_addr = '0; cl_req_tag = '0; cl_req_data = '0;
    cl_resp_ready = 1'b0; mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
  endtask

  // Plays client and responder for one transaction, recording what it sees.
  task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [LW-1:0] wline, input int cmd_stall, input bit toggle_dr,
                         input int bad_after, input logic [TW-1:0] bad_tag, input int resp_hold,
                         input bit keep_valid, input int abort_after, input bit noise);
    int t, stall_left, rd_sent, hold_left;
    bit fired, cmd_acc, done, bad_done, resp_seen;
    logic [LW-1:0] rline;
    o_cmd_cnt = 0; o_cmd_cyc = -1; o_done_cyc = -1; o_wr_done_cnt = 0;
    o_first_cmd = 1'b0; o_cmd_unstable = 1'b0; o_dv_early = 1'b0;
    o_resp_unstable = 1'b0; o_stall_violation = 1'b0; o_aborted = 1'b0;
    o_wbeats.delete();
    if (!rw && !mem_model.exists(addr)) mem_model[addr] = rand_line();
    rline = rw ? '0 : mem_model[addr];
    stall_left = cmd_stall; rd_sent = 0; hold_left = resp_hold;
    fired = 1'b0; cmd_acc = 1'b0; done = 1'b0; bad_done = 1'b0; resp_seen = 1'b0;
    t = 0;
    while (!done && t < 300) begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; cl_resp_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_tag = TW'($urandom); mem_resp_data = rand_beat();
      if (abort_after >= 0 && o_wbeats.size() == abort_after) begin
        idle_inputs();
        reset = 1'b1; o_aborted = 1'b1; done = 1'b1;
      end else begin
        if (!fired || keep_valid) begin
          cl_req_valid = 1'b1; cl_req_rw = rw; cl_req_addr = addr; cl_req_tag = tag; cl_req_data = wline;
          if (cl_req_ready) fired = 1'b1;
        end else begin
          // Request is latched by now; scramble the client bus.
          cl_req_valid = 1'b0; cl_req_rw = 1'($urandom); cl_req_addr = AW'($urandom);
          cl_req_tag = TW'($urandom); cl_req_data = rand_line();
        end
        if (mem_req_data_valid) begin
          if (!cmd_acc) o_dv_early = 1'b1;
          if (!toggle_dr || (t % 2 == 0)) begin
            mem_req_data_ready = 1'b1;
            o_wbeats.push_back(mem_req_data_bits);
          end
        end
        if (mem_req_valid) begin
          if (!o_first_cmd) begin
            o_first_cmd = 1'b1; o_cmd_rw = mem_req_rw; o_cmd_addr = mem_req_addr; o_cmd_tag = mem_req_tag;
          end else if (!cmd_acc && (mem_req_rw !== o_cmd_rw || mem_req_addr !== o_cmd_addr ||
                                    mem_req_tag !== o_cmd_tag)) begin
            o_cmd_unstable = 1'b1;
          end
          if (stall_left > 0) stall_left--;
          else begin
            mem_req_ready = 1'b1; o_cmd_cnt++; o_cmd_cyc = t; cmd_acc = 1'b1;
          end
        end
        if (!rw && cmd_acc && t > o_cmd_cyc && rd_sent < NB) begin
          mem_resp_valid = 1'b1;
          if (bad_after == rd_sent && !bad_done) begin
            mem_resp_tag = bad_tag; bad_done = 1'b1;
          end else begin
            mem_resp_tag = tag; mem_resp_data = rline[rd_sent*DW +: DW]; rd_sent++;
          end
        end else if (noise) begin
          mem_resp_valid = 1'($urandom_range(0, 1));
        end
        if (wr_done) begin
          o_wr_done_cnt++;
          if (o_done_cyc < 0) o_done_cyc = t;
          if (rw) done = 1'b1;
        end
        if (cl_resp_valid) begin
          if (!resp_seen) begin
            resp_seen = 1'b1; o_done_cyc = t; o_resp_data = cl_resp_data; o_resp_tag = cl_resp_tag;
          end else if (cl_resp_data !== o_resp_data || cl_resp_tag !== o_resp_tag) begin
            o_resp_unstable = 1'b1;
          end
          if (cl_req_ready || mem_req_valid) o_stall_violation = 1'b1;
          if (hold_left > 0) hold_left--;
          else begin
            cl_resp_ready = 1'b1; done = 1'b1;
          end
        end
      end
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout: still running after %0d cycles, required completion (rw=%0b addr=%h)", t, rw, addr);
    end else if (rw && !o_aborted) begin
      mem_model[addr] = wline;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cl_req_ready !== 1'b1) begin errors++; $display("FAIL reset_cl_req_ready: got %b want 1", cl_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (mem_req_data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", mem_req_data_valid); end
    checks++; if (cl_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_cl_resp_valid: got %b want 0", cl_resp_valid); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    logic [LW-1:0] line;
    line = {128'hD, 128'hC, 128'hB, 128'hA};
    run_txn(1'b1, 26'h10, 5'd3, line, 0, 1'b0, -1, '0, 0, 1'b0, -1, 1'b0);
    checks++; if (o_cmd_cnt !== 1) begin errors++; $display("FAIL write_cmd_count: got %0d want 1", o_cmd_cnt); end
    checks++; if ({o_cmd_rw, o_cmd_addr, o_cmd_tag} !== {1'b1, 26'h10, 5'd3}) begin
      errors++; $display("FAIL write_cmd_fields: got rw=%b addr=%h tag=%0d want rw=1 addr=10 tag=3", o_cmd_rw, o_cmd_addr, o_cmd_tag); end
    checks++; if (o_wbeats.size() != NB || pack_wbeats() !== line) begin
      errors++; $display("FAIL write_beats: got %0d beats %h want 4 beats %h", o_wbeats.size(), pack_wbeats(), line); end
    checks++; if (o_cmd_cyc !== 1) begin errors++; $display("FAIL write_cmd_cycle: got t%0d want t1", o_cmd_cyc); end
    checks++; if (o_done_cyc !== 6) begin errors++; $display("FAIL write_done_cycle: got t%0d want t6", o_done_cyc); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL write_done_pulse_width: got %b want 0", wr_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL write_err: got %b want 0", err); end
  endtask

  task automatic test_read();
    logic [LW-1:0] exp_line;
    exp_line = {128'hD, 128'hC, 128'hB, 128'hA};
    run_txn(1'b0, 26'h10, 5'd4, '0, 0, 1'b0, -1, '0, 0, 1'b0, -1, 1'b0);
    checks++; if ({o_cmd_cnt, o_cmd_rw, o_cmd_tag} !== {32'd1, 1'b0, 5'd4}) begin
      errors++; $display("FAIL read_cmd: got cnt=%0d rw=%b tag=%0d want cnt=1 rw=0 tag=4", o_cmd_cnt, o_cmd_rw, o_cmd_tag); end
    checks++; if (o_done_cyc !== 6) begin errors++; $display("FAIL read_resp_cycle: got t%0d want t6", o_done_cyc); end
    checks++; if (o_resp_data !== exp_line) begin errors++; $display("FAIL read_data: got %h want %h", o_resp_data, exp_line); end
    checks++; if (o_resp_tag !== 5'd4) begin errors++; $display("FAIL read_tag: got %0d want 4", o_resp_tag); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] line;
    line = rand_line();
    run_txn(1'b1, 26'h30, 5'd2, line, 5, 1'b1, -1, '0, 0, 1'b0, -1, 1'b0);
    checks++; if (o_cmd_unstable !== 1'b0) begin errors++; $display("FAIL bp_cmd_stable: got unstable=%b want 0", o_cmd_unstable); end
    checks++; if (o_dv_early !== 1'b0) begin errors++; $display("FAIL bp_data_before_cmd: got %b want 0", o_dv_early); end
    checks++; if (o_cmd_cnt !== 1 || o_cmd_cyc !== 6) begin
      errors++; $display("FAIL bp_cmd_accept: got cnt=%0d at t%0d want cnt=1 at t6", o_cmd_cnt, o_cmd_cyc); end
    checks++; if (o_wbeats.size() != NB || pack_wbeats() !== line) begin
      errors++; $display("FAIL bp_beats: got %0d beats %h want 4 beats %h", o_wbeats.size(), pack_wbeats(), line); end
    checks++; if (o_done_cyc !== 15) begin errors++; $display("FAIL bp_done_cycle: got t%0d want t15", o_done_cyc); end
  endtask

  task automatic test_bad_tag();
    run_txn(1'b0, 26'h40, 5'd9, '0, 0, 1'b0, 2, 5'd7, 0, 1'b0, -1, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badtag_err: got %b want 1", err); end
    checks++; if (o_resp_data !== mem_model[26'h40]) begin
      errors++; $display("FAIL badtag_line: got %h want %h", o_resp_data, mem_model[26'h40]); end
    checks++; if (o_resp_tag !== 5'd9 || o_done_cyc !== 7) begin
      errors++; $display("FAIL badtag_resp: got tag=%0d t%0d want tag=9 t7", o_resp_tag, o_done_cyc); end
    run_txn(1'b1, 26'h40, 5'd1, rand_line(), 0, 1'b0, -1, '0, 0, 1'b0, -1, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badtag_sticky: got %b want 1", err); end
  endtask

  task automatic test_resp_stall();
    run_txn(1'b0, 26'h10, 5'd11, '0, 0, 1'b0, -1, '0, 10, 1'b1, -1, 1'b0);
    checks++; if (o_stall_violation !== 1'b0) begin errors++; $display("FAIL stall_no_new_req: got violation=%b want 0", o_stall_violation); end
    checks++; if (o_resp_unstable !== 1'b0) begin errors++; $display("FAIL stall_resp_stable: got unstable=%b want 0", o_resp_unstable); end
    checks++; if (o_resp_data !== mem_model[26'h10] || o_done_cyc !== 6) begin
      errors++; $display("FAIL stall_resp: got %h at t%0d want %h at t6", o_resp_data, o_done_cyc, mem_model[26'h10]); end
    @(posedge clk); #1;
    cl_resp_ready = 1'b0;
    checks++; if ({cl_req_ready, mem_req_valid, cl_resp_valid} !== 3'b100) begin
      errors++; $display("FAIL stall_after_hs1: got ready/mreq/resp=%b%b%b want 100", cl_req_ready, mem_req_valid, cl_resp_valid); end
    @(posedge clk); #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 5'd11) begin
      errors++; $display("FAIL stall_after_hs2: got mem_req_valid=%b tag=%0d want 1 tag=11", mem_req_valid, mem_req_tag); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_err_sticky: got %b want 1", err); end
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [LW-1:0] line, line2;
    line = rand_line();
    run_txn(1'b1, 26'h20, 5'd6, line, 0, 1'b0, -1, '0, 0, 1'b0, 2, 1'b0);
    checks++; if (o_aborted !== 1'b1 || o_wbeats.size() != 2 || pack_wbeats() !== {{(LW-2*DW){1'b0}}, line[2*DW-1:0]}) begin
      errors++; $display("FAIL rst_mid_first_beats: got %0d beats want 2 matching line", o_wbeats.size()); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({cl_req_ready, mem_req_valid, mem_req_data_valid, cl_resp_valid, wr_done} !== 5'b10000) begin
      errors++; $display("FAIL rst_mid_idle: got rdy/mreq/dv/resp/done=%b%b%b%b%b want 10000",
                         cl_req_ready, mem_req_valid, mem_req_data_valid, cl_resp_valid, wr_done); end
    @(posedge clk); #1;
    checks++; if (wr_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_done: got wr_done=%b err=%b want 0 0", wr_done, err); end
    line2 = rand_line();
    run_txn(1'b1, 26'h20, 5'd6, line2, 0, 1'b0, -1, '0, 0, 1'b0, -1, 1'b0);
    checks++; if (o_wbeats.size() != NB || pack_wbeats() !== line2 || o_done_cyc !== 6) begin
      errors++; $display("FAIL rst_mid_next_write: got %0d beats done t%0d want 4 matching beats done t6", o_wbeats.size(), o_done_cyc); end
  endtask

  task automatic test_random();
    logic          rw;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [LW-1:0] line;
    for (int n = 0; n < 24; n++) begin
      rw   = 1'($urandom);
      addr = AW'(26'h100 + $urandom_range(0, 3));
      tag  = TW'($urandom);
      line = rand_line();
      run_txn(rw, addr, tag, line, int'($urandom_range(0, 2)), 1'($urandom), -1, '0,
              int'($urandom_range(0, 3)), 1'b0, -1, 1'b1);
      checks++; if (o_cmd_cnt !== 1 || {o_cmd_rw, o_cmd_addr, o_cmd_tag} !== {rw, addr, tag}) begin
        errors++; $display("FAIL rand_cmd[%0d]: got cnt=%0d rw=%b addr=%h tag=%0d want 1 %b %h %0d",
                           n, o_cmd_cnt, o_cmd_rw, o_cmd_addr, o_cmd_tag, rw, addr, tag); end
      if (rw) begin
        checks++; if (o_wbeats.size() != NB || pack_wbeats() !== line || o_wr_done_cnt !== 1) begin
          errors++; $display("FAIL rand_write[%0d]: got %0d beats, %0d done pulses want 4 matching, 1", n, o_wbeats.size(), o_wr_done_cnt); end
      end else begin
        checks++; if (o_resp_data !== mem_model[addr] || o_resp_tag !== tag) begin
          errors++; $display("FAIL rand_read[%0d]: got %h tag %0d want %h tag %0d", n, o_resp_data, o_resp_tag, mem_model[addr], tag); end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err_clean: got %b want 0", err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_bad_tag();
    test_resp_stall();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
